// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the multicycle CPU: serialises fetch and load/store accesses.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2    // 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic {OwnIf = 1'b0, OwnD = 1'b1} owner_e;

  localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

  state_e            r_state, w_state_d;
  owner_e            r_owner, w_owner_d;
  owner_e            w_grant;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [DATA_W-1:0] r_wdata, w_wdata_d;
  logic              r_we, w_we_d;
  logic [DATA_W-1:0] r_rdata, w_rdata_d;

`ifdef MEM_ARB_RR_EN
  owner_e r_last_owner;

  // On a tie, favour whichever requester was not granted most recently.
  always_comb begin
    w_grant = i_d_req ? OwnD : OwnIf;
    if (i_if_req && i_d_req) begin
      w_grant = (r_last_owner == OwnIf) ? OwnD : OwnIf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OwnIf;
    end else if (r_state == StIdle && (i_if_req || i_d_req)) begin
      r_last_owner <= w_grant;
    end
  end
`else
  always_comb begin
    w_grant = i_d_req ? OwnD : OwnIf;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_owner <= OwnIf;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
      r_cnt   <= w_cnt_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_we    <= w_we_d;
      r_rdata <= w_rdata_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_cnt_d   = r_cnt;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_we_d    = r_we;
    w_rdata_d = r_rdata;
    unique case (r_state)
      StIdle: begin
        if (i_if_req || i_d_req) begin
          w_state_d = StAccess;
          w_owner_d = w_grant;
          w_cnt_d   = CntInit;
          if (w_grant == OwnD) begin
            w_addr_d  = i_d_addr;
            w_wdata_d = i_d_wdata;
            w_we_d    = i_d_we;
          end else begin
            w_addr_d = i_if_addr;
            w_we_d   = 1'b0;
          end
        end
      end
      StAccess: begin
        if (r_cnt == 4'd0) begin
          w_state_d = StDone;
          if (!r_we) begin
            w_rdata_d = i_mem_rdata;
          end
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs come only from registered state so requests never reach the memory combinationally.
  always_comb begin
    o_mem_cs    = (r_state == StAccess);
    o_mem_we    = (r_state == StAccess) && r_we;
    o_mem_addr  = r_addr;
    o_mem_wdata = r_wdata;
    o_if_ack    = (r_state == StDone) && (r_owner == OwnIf);
    o_d_ack     = (r_state == StDone) && (r_owner == OwnD);
    o_busy      = (r_state != StIdle);
    o_rdata     = r_rdata;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter/sequencer for the multicycle CPU. It shares one unified instruction/data memory between the fetch stage (IF state) and the load/store stage (MEM states).
- Grants one requester at a time and latches the request.
- Drives the memory for a fixed number of wait-state cycles, then returns read data with a one-cycle ack pulse.
- Sits between the control unit/datapath and the memory. The control unit holds its state while waiting for ack.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles mem_cs is held per access; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request (read only); level, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse: fetch complete, rdata valid.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse: data access complete.
- rdata  out  DATA_W  registered read data, shared by both requesters.
- mem_cs  out  1  memory select.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data, valid in last ACCESS cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, owner=IF, cnt=0, rdata=0, last_owner=IF.
  - All outputs 0 immediately, including mid-access; a partially driven write is abandoned.
- States: IDLE, ACCESS, DONE. Outputs are decoded from the registered state/owner; no req-to-output combinational path.
- IDLE:
  - On a posedge with any req high: pick owner, latch addr/we/wdata (we=0 for IF), cnt=MEM_LAT-1, go to ACCESS.
  - No req: stay in IDLE.
- Arbitration: fixed priority, data over fetch, because an in-flight load/store must finish before the next fetch.
  - When both reqs are high in the same IDLE cycle, d wins; if_req keeps waiting.
- ACCESS:
  - mem_cs=1; mem_we=latched we; mem_addr/mem_wdata=latched values.
  - cnt decrements each cycle.
  - When cnt==0: on a read, rdata<=mem_rdata; on a write, rdata is unchanged. Go to DONE.
- DONE:
  - mem_cs=0; the owner's ack=1 for exactly this cycle.
  - Next posedge: unconditionally go to IDLE. One bubble cycle is mandatory between accesses.
- Latency: req high at posedge N -> mem_cs high during cycles N+1..N+MEM_LAT -> ack high in cycle N+MEM_LAT+1 -> the next grant is evaluated no earlier than posedge N+MEM_LAT+2.
- Handshake:
  - Requester drops req in the cycle after ack.
  - Address/data changes after grant are ignored.
  - If req is withdrawn before ack, the access still completes and ack still pulses; a store always takes effect.
- A req still high in IDLE after its own ack is treated as a new request. The control unit must drop it.
- if_ack and d_ack are never high together. busy=1 in ACCESS and DONE.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, grant the requester that was not granted last; last_owner updates at each grant, and its reset value is IF, so the first tie goes to d.
- Undefined: fixed d-over-IF priority as above; last_owner logic is absent.
- Single-request behaviour and latency are identical in both builds.

Test Plan:
- Fetch: MEM_LAT=2; if_req=1, if_addr=0x40, memory returns 0x02010003 -> mem_cs high for 2 cycles with mem_addr=0x40 and mem_we=0; if_ack pulses in the 3rd cycle after the grant edge; rdata=0x02010003.
- Store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> mem_we=1 for 2 cycles; memory word 0x10=0xDEADBEEF; d_ack pulses once; rdata keeps its previous value.
- Tie: if_req and d_req raised in the same cycle -> d is served first, then if_ack follows at cycle 7 after the grant edge (3-cycle access + bubble + 3-cycle access). With MEM_ARB_RR_EN, a second tie immediately afterwards is served IF first.
- Withdrawn request: d_req=1, d_we=1 dropped after 1 cycle of ACCESS -> the write still lands and d_ack still pulses.
- Reset: assert rst_n=0 in the middle of ACCESS -> mem_cs, mem_we, busy and rdata are 0 before the next clk edge; after release, state is IDLE and no ack is issued.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15 -> request-to-ack distance is 2 and 16 posedges; mem_cs width is 1 and 15 cycles.
